reg_file_bist: RTL and testbench

Built-in self-test controller for the 16 x 32 register file. It acts as the initiator on the register file's port set: it drives the write port and both read ports, and checks the read data. On a `start` pulse it runs two write/read-back passes over every address, using a pattern and then its inverse, and reports pass/fail, an error count and the first failing location. It sits beside `reg_file` and is muxed onto the register file ports during test.

---
 rtl/reg_file_bist.sv | 195 +++++++++++++++++++
 tb/tb_reg_file_bist.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_bist.sv
// -----------------------------------------------------------------------------
// reg_file_bist
//
// Built-in self-test controller for the register file. It acts as initiator on
// the register file port set. On a start pulse it runs two write/read-back
// passes over every address: pass 0 writes pat(0,a) = a replicated across the
// word, and pass 1 writes its inverse. The two read ports check addresses a and
// ~a in the same cycle. The controller reports pass/fail, a mismatch count and
// the first failing location.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle run request, honoured only in IDLE
//   wr_en, write_addr,
//   write_data          register file write port
//   read_addr1/2        register file read addresses (a and ~a)
//   read_data1/2        register file read data (combinational in the RF)
//   busy                high while writing or reading
//   done                one-cycle completion pulse
//   pass                last run had zero mismatches (held until next start)
//   err_count           number of mismatching port-reads (max 64)
//   first_fail_addr     register address of the first mismatch
//   first_fail_port     0 = read port 1, 1 = read port 2
//   first_fail_pass     pass index of the first mismatch
// -----------------------------------------------------------------------------
module reg_file_bist #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    wr_en,
    output logic [ADDR_WIDTH-1:0]   write_addr,
    output logic [DATA_WIDTH-1:0]   write_data,
    output logic [ADDR_WIDTH-1:0]   read_addr1,
    output logic [ADDR_WIDTH-1:0]   read_addr2,
    input  logic [DATA_WIDTH-1:0]   read_data1,
    input  logic [DATA_WIDTH-1:0]   read_data2,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [ADDR_WIDTH+2:0]   err_count,
    output logic [ADDR_WIDTH-1:0]   first_fail_addr,
    output logic                    first_fail_port,
    output logic                    first_fail_pass
);

    localparam int ERR_W = ADDR_WIDTH + 3;
    localparam int REPS  = DATA_WIDTH / ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] A_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DONE
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   a;
    logic                    p;

    // Test pattern: the address replicated across the word, inverted in pass 1.
    function automatic logic [DATA_WIDTH-1:0] pat(input logic inv,
                                                  input logic [ADDR_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] base;
        base = {REPS{addr}};
        return inv ? ~base : base;
    endfunction

    // ------------------------------------------------------------------
    // Read-back comparison (only consumed in READ)
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] a_inv;
    logic                  miss1;
    logic                  miss2;
    logic [ERR_W-1:0]      miss_cnt;
    logic [ERR_W-1:0]      err_next;

    // NOTE: every signal driven in always_comb gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        a_inv    = ~a;
        miss1    = (read_data1 != pat(p, a));
        miss2    = (read_data2 != pat(p, a_inv));
        miss_cnt = ERR_W'(miss1) + ERR_W'(miss2);
        err_next = err_count + miss_cnt;
    end

    // ------------------------------------------------------------------
    // Output decode: a pure function of state registers, so there is no
    // input-to-output path and reset clears the outputs immediately.
    // ------------------------------------------------------------------
    always_comb begin
        wr_en      = 1'b0;
        write_addr = '0;
        write_data = '0;
        read_addr1 = '0;
        read_addr2 = '0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_WRITE: begin
                wr_en      = 1'b1;
                write_addr = a;
                write_data = pat(p, a);
                busy       = 1'b1;
            end
            S_READ: begin
                read_addr1 = a;
                read_addr2 = a_inv;
                busy       = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer and result registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            a               <= '0;
            p               <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_fail_addr <= '0;
            first_fail_port <= 1'b0;
            first_fail_pass <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a               <= '0;
                        p               <= 1'b0;
                        pass            <= 1'b0;
                        err_count       <= '0;
                        first_fail_addr <= '0;
                        first_fail_port <= 1'b0;
                        first_fail_pass <= 1'b0;
                        state           <= S_WRITE;
                    end
                end

                S_WRITE: begin
                    if (a == A_MAX) begin
                        a     <= '0;
                        state <= S_READ;
                    end else begin
                        a <= a + 1'b1;
                    end
                end

                S_READ: begin
                    err_count <= err_next;
                    // A zero count means nothing has failed yet in this run.
                    // Port 1 takes priority; the recorded address is the one
                    // actually presented on the failing port.
                    if (err_count == '0 && (miss1 || miss2)) begin
                        first_fail_addr <= miss1 ? a : a_inv;
                        first_fail_port <= ~miss1;
                        first_fail_pass <= p;
                    end
                    if (a == A_MAX) begin
                        a <= '0;
                        if (!p) begin
                            p     <= 1'b1;
                            state <= S_WRITE;
                        end else begin
                            // Verdict includes the compare made in this cycle.
                            pass  <= (err_next == '0);
                            state <= S_DONE;
                        end
                    end else begin
                        a <= a + 1'b1;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_bist.sv
// -----------------------------------------------------------------------------
// tb_reg_file_bist
//
// Directed bench for reg_file_bist. A behavioural 16 x 32 register file sits on
// the BIST ports; an optional fault makes register 3 read with bit 0 stuck at 1.
// Cycle numbering: start is sampled at edge 0, cycle N lies between edges N-1
// and N, and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_reg_file_bist;

    localparam int DW = 32;
    localparam int AW = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           wr_en;
    logic [AW-1:0]  write_addr;
    logic [DW-1:0]  write_data;
    logic [AW-1:0]  read_addr1;
    logic [AW-1:0]  read_addr2;
    logic [DW-1:0]  read_data1;
    logic [DW-1:0]  read_data2;
    logic           busy;
    logic           done;
    logic           pass;
    logic [AW+2:0]  err_count;
    logic [AW-1:0]  first_fail_addr;
    logic           first_fail_port;
    logic           first_fail_pass;

    reg_file_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .wr_en           (wr_en),
        .write_addr      (write_addr),
        .write_data      (write_data),
        .read_addr1      (read_addr1),
        .read_addr2      (read_addr2),
        .read_data1      (read_data1),
        .read_data2      (read_data2),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .first_fail_addr (first_fail_addr),
        .first_fail_port (first_fail_port),
        .first_fail_pass (first_fail_pass)
    );

    always #5 clk = ~clk;

    // Register file model with an optional stuck-at-1 on register 3 bit 0.
    logic [DW-1:0] mem [16];
    logic          stuck = 1'b0;

    always @(posedge clk) begin
        if (wr_en) mem[write_addr] <= write_data;
    end

    assign read_data1 = mem[read_addr1] | ((stuck && read_addr1 == 4'd3) ? 32'd1 : 32'd0);
    assign read_data2 = mem[read_addr2] | ((stuck && read_addr2 == 4'd3) ? 32'd1 : 32'd0);

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observations from the most recent monitored run.
    int            done_cyc;
    int            done_n;
    int            busy_n;
    logic          we6, we38;
    logic [AW-1:0] wa6, wa38;
    logic [DW-1:0] wd6, wd38;
    logic [AW-1:0] ra1_17, ra2_17;
    logic [AW+2:0] err33;

    // Start sampled at the next edge: leaves the bench in cycle 1.
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Observe cycles 1..66; extra start requests are driven during cycles s1, s2.
    // Returns while sampling cycle 66 (no further edge consumed).
    task automatic monitor(input int s1, input int s2);
        done_cyc = 0;
        done_n   = 0;
        busy_n   = 0;
        for (int cyc = 1; cyc <= 66; cyc++) begin
            if (done) begin
                done_n++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (busy) busy_n++;
            if (cyc == 6)  begin we6 = wr_en; wa6 = write_addr; wd6 = write_data; end
            if (cyc == 38) begin we38 = wr_en; wa38 = write_addr; wd38 = write_data; end
            if (cyc == 17) begin ra1_17 = read_addr1; ra2_17 = read_addr2; end
            if (cyc == 33) err33 = err_count;
            if (cyc < 66) begin
                start = (cyc == s1 || cyc == s2);
                tick();
            end
        end
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_addrs"}, {write_addr, read_addr1, read_addr2}, 0);
        check({tag, "_wdata"}, write_data, 0);
        check({tag, "_results"}, {pass, err_count, first_fail_addr, first_fail_port, first_fail_pass}, 0);
    endtask

    initial begin
        // ---------------- power-on reset ----------------
        #12;
        check_all_zero("por");
        rst_n = 1'b1;
        tick();

        // ---------------- fault-free run ----------------
        pulse_start();
        monitor(0, 0);
        check("ok_we6", we6, 1);
        check("ok_wa6", wa6, 5);
        check("ok_wd6", wd6, 32'h5555_5555);
        check("ok_we38", we38, 1);
        check("ok_wa38", wa38, 5);
        check("ok_wd38", wd38, 32'hAAAA_AAAA);
        check("ok_raddr17", {ra1_17, ra2_17}, {4'd0, 4'd15});
        check("ok_done_cyc", done_cyc, 65);
        check("ok_done_n", done_n, 1);
        check("ok_busy_n", busy_n, 64);
        check("ok_pass", pass, 1);
        check("ok_err", err_count, 0);
        check("ok_idle66", {busy, done}, 0);

        // ---------------- stuck-at-1 on register 3 bit 0 ----------------
        stuck = 1'b1;
        pulse_start();
        monitor(0, 0);
        check("sa_pass0_clean", err33, 0);
        check("sa_done_cyc", done_cyc, 65);
        check("sa_err", err_count, 2);
        check("sa_ff_addr", first_fail_addr, 3);
        check("sa_ff_port", first_fail_port, 0);
        check("sa_ff_pass", first_fail_pass, 1);
        check("sa_pass", pass, 0);

        // ---------------- back-to-back start in cycle 66 ----------------
        stuck = 1'b0;
        pulse_start();
        check("b2b_cleared", {pass, err_count, first_fail_addr, first_fail_pass}, 0);
        check("b2b_busy", busy, 1);
        monitor(0, 0);
        check("b2b_done_cyc", done_cyc, 65);
        check("b2b_pass", pass, 1);
        check("b2b_err", err_count, 0);

        // ---------------- extra starts in cycles 10 and 65 ignored ----------------
        pulse_start();
        monitor(10, 65);
        check("ign_done_cyc", done_cyc, 65);
        check("ign_done_n", done_n, 1);
        check("ign_busy_n", busy_n, 64);
        check("ign_pass", pass, 1);

        // ---------------- reset mid-write (cycle 5) ----------------
        pulse_start();
        for (int i = 0; i < 4; i++) tick();
        check("rst5_pre_wr_en", {wr_en, write_addr}, {1'b1, 4'd4});
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("rst5");
        #2 rst_n = 1'b1;
        tick();

        // ---------------- reset mid-read (cycle 20), then a full run ----------------
        pulse_start();
        for (int i = 0; i < 19; i++) tick();
        check("rst20_pre", {busy, read_addr1, read_addr2}, {1'b1, 4'd3, 4'd12});
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("rst20");
        #2 rst_n = 1'b1;
        tick();
        pulse_start();
        monitor(0, 0);
        check("post_rst_done_cyc", done_cyc, 65);
        check("post_rst_busy_n", busy_n, 64);
        check("post_rst_pass", pass, 1);
        check("post_rst_err", err_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
